// File: rtl/fetch_queue.sv
// Instruction fetch queue: sequential imem reads, in-order PC-tagged FIFO, redirect flush.
// Optional FETCH_QUEUE_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module fetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter int                PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         imem_req,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic                         imem_ready,
  input  logic                         imem_rvalid,
  input  logic [INSTR_W-1:0]           imem_rdata,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_pc,
  output logic                         instr_valid,
  output logic [INSTR_W-1:0]           instr,
  output logic [ADDR_W-1:0]            instr_pc,
  input  logic                         instr_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);
  // Drops are not credit-limited, so repeated redirects against a slow memory can stack them up.
  localparam int DROP_W = CNT_W + 4;
  localparam logic [CNT_W:0]    DEPTH_C = (CNT_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

  logic [INSTR_W-1:0] r_instrMem [DEPTH];
  logic [ADDR_W-1:0]  r_pcMem    [DEPTH];
  logic [PTR_W-1:0]   r_rdPtr;
  logic [PTR_W-1:0]   r_wrPtr;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_inflight;
  logic [DROP_W-1:0]  r_dropCnt;
  logic [ADDR_W-1:0]  r_fetchPc;
  logic [ADDR_W-1:0]  r_respPc;

  logic w_credit;
  logic w_accept;
  logic w_rspDrop;
  logic w_rspTake;
  logic w_push;
  logic w_pop;

  assign w_credit  = ({1'b0, r_count} + {1'b0, r_inflight}) < DEPTH_C;
  assign imem_req  = reset & ~redirect & w_credit;
  assign imem_addr = r_fetchPc;
  assign w_accept  = imem_req & imem_ready;
  assign w_rspDrop = imem_rvalid & (r_dropCnt != '0);
  assign w_rspTake = imem_rvalid & (r_dropCnt == '0) & (r_inflight != '0);
  assign w_pop     = (r_count != '0) & instr_ready & ~redirect;
  assign count     = r_count;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic w_bypass;
  assign w_bypass    = (r_count == '0) & ~redirect & w_rspTake;
  assign instr_valid = (r_count != '0) | w_bypass;
  assign instr       = w_bypass ? imem_rdata : r_instrMem[r_rdPtr];
  assign instr_pc    = w_bypass ? r_respPc   : r_pcMem[r_rdPtr];
  assign w_push      = w_rspTake & ~redirect & ~(w_bypass & instr_ready);
`else
  assign instr_valid = (r_count != '0);
  assign instr       = r_instrMem[r_rdPtr];
  assign instr_pc    = r_pcMem[r_rdPtr];
  assign w_push      = w_rspTake & ~redirect;
`endif

  // Redirect turns everything still outstanding into drops and restarts both PC streams.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_dropCnt  <= '0;
      r_fetchPc  <= RESET_PC;
      r_respPc   <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        r_instrMem[i] <= '0;
        r_pcMem[i]    <= '0;
      end
    end else if (redirect) begin
      r_rdPtr    <= '0;
      r_wrPtr    <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_fetchPc  <= redirect_pc;
      r_respPc   <= redirect_pc;
      r_dropCnt  <= r_dropCnt + DROP_W'(r_inflight) - DROP_W'(w_rspTake) - DROP_W'(w_rspDrop);
    end else begin
      if (w_accept) r_fetchPc <= r_fetchPc + STEP_C;
      if (w_rspTake) r_respPc <= r_respPc + STEP_C;
      if (w_rspDrop) r_dropCnt <= r_dropCnt - DROP_W'(1);
      r_inflight <= r_inflight + CNT_W'(w_accept) - CNT_W'(w_rspTake);
      if (w_push) begin
        r_instrMem[r_wrPtr] <= imem_rdata;
        r_pcMem[r_wrPtr]    <= r_respPc;
        r_wrPtr             <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) r_rdPtr <= r_rdPtr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: queue-based reference model, in-order memory model,
// directed scenarios plus a randomized run. Honours FETCH_QUEUE_BYPASS_EN when defined.
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic [2:0]  count;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .count(count)
  );

  typedef struct packed { logic [15:0] data; logic [15:0] pc; } entry_t;
  typedef struct { int due; logic [15:0] addr; } memReq_t;

  entry_t      mQ[$];
  logic [15:0] mFetch = '0;
  logic [15:0] mResp = '0;
  int          mInfl = 0;
  int          mDrop = 0;

  memReq_t     memQ[$];
  int          lastDue = 0;
  int          memLat = 1;
  int          cyc = 0;
  logic        spurious = 1'b0;
  logic        snapReq = 1'b0;
  logic [15:0] snapAddr = '0;
  logic [15:0] popLog[$];

  int          imemReadyPct = 100;
  int          instrReadyPct = 100;
  int          redirPct = 0;
  int          spurPct = 0;
  bit          forceRedir = 1'b0;
  logic [15:0] forcePc = '0;

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    bit eReq, take, byp, eValid;
    eReq   = reset && !redirect && (mQ.size() + mInfl < 4);
    take   = imem_rvalid && (mDrop == 0) && (mInfl > 0);
    byp    = BYP && reset && (mQ.size() == 0) && !redirect && take;
    eValid = (mQ.size() != 0) || byp;
    checkOutput("imem_req", {31'b0, imem_req}, {31'b0, eReq});
    checkOutput("imem_addr", {16'b0, imem_addr}, {16'b0, mFetch});
    checkOutput("count", {29'b0, count}, mQ.size());
    checkOutput("instr_valid", {31'b0, instr_valid}, {31'b0, eValid});
    if (eValid) begin
      checkOutput("instr", {16'b0, instr}, {16'b0, byp ? imem_rdata : mQ[0].data});
      checkOutput("instr_pc", {16'b0, instr_pc}, {16'b0, byp ? mResp : mQ[0].pc});
    end
    if (reset && instr_valid && instr_ready && !redirect) popLog.push_back(instr_pc);
    snapReq  = imem_req;
    snapAddr = imem_addr;
  end

  // Reference model and memory model advance on each rising edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mQ.delete();
      memQ.delete();
      mFetch  = 16'h0000;
      mResp   = 16'h0000;
      mInfl   = 0;
      mDrop   = 0;
      lastDue = 0;
    end else begin
      bit eReq, acc, drop, take, byp;
      eReq = !redirect && (mQ.size() + mInfl < 4);
      acc  = eReq && imem_ready;
      drop = imem_rvalid && (mDrop > 0);
      take = imem_rvalid && (mDrop == 0) && (mInfl > 0);
      if (redirect) begin
        mDrop  = mDrop - int'(drop) + mInfl - int'(take);
        mInfl  = 0;
        mQ.delete();
        mFetch = redirect_pc;
        mResp  = redirect_pc;
      end else begin
        byp = BYP && (mQ.size() == 0) && take;
        if (mQ.size() > 0 && instr_ready) void'(mQ.pop_front());
        if (take) begin
          if (!(byp && instr_ready)) mQ.push_back({imem_rdata, mResp});
          mResp = mResp + 16'd4;
        end
        if (drop) mDrop--;
        mInfl = mInfl + int'(acc) - int'(take);
        if (acc) mFetch = mFetch + 16'd4;
      end
      if (imem_rvalid && !spurious && memQ.size() > 0) void'(memQ.pop_front());
      if (snapReq && imem_ready) begin
        memReq_t r;
        r.due   = (cyc + memLat > lastDue + 1) ? cyc + memLat : lastDue + 1;
        r.addr  = snapAddr;
        lastDue = r.due;
        memQ.push_back(r);
      end
      cyc++;
    end
  end

  task automatic applyStimulus();
    if (forceRedir) begin
      redirect    = 1'b1;
      redirect_pc = forcePc;
      forceRedir  = 1'b0;
    end else if (reset && $urandom_range(99) < redirPct) begin
      redirect    = 1'b1;
      redirect_pc = ($urandom_range(3) == 0) ? 16'hFFF8 : (16'($urandom) & 16'hFFFC);
    end else begin
      redirect    = 1'b0;
      redirect_pc = 16'($urandom);
    end
    imem_ready  = ($urandom_range(99) < imemReadyPct);
    instr_ready = ($urandom_range(99) < instrReadyPct);
    if (memQ.size() > 0 && memQ[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memQ[0].addr ^ 16'hA5A5;
      spurious    = 1'b0;
    end else if (memQ.size() == 0 && $urandom_range(99) < spurPct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 16'($urandom);
      spurious    = 1'b1;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 16'($urandom);
      spurious    = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    applyStimulus();
  endtask

  task automatic holdReset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    redirect = 1'b0;
    imem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus();
  endtask

  task automatic checkSeq(input string name, input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
    checkOutput({name, "_len"}, {31'b0, popLog.size() >= 3}, 32'd1);
    if (popLog.size() >= 3) begin
      checkOutput({name, "_0"}, {16'b0, popLog[0]}, {16'b0, e0});
      checkOutput({name, "_1"}, {16'b0, popLog[1]}, {16'b0, e1});
      checkOutput({name, "_2"}, {16'b0, popLog[2]}, {16'b0, e2});
    end
  endtask

  initial begin
    int firstK;
    int stale;
    bit seen;
    logic [15:0] firstPc, firstIn;

    #2;
    checkOutput("reset_instr_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("reset_imem_req", {31'b0, imem_req}, 32'd0);
    checkOutput("reset_count", {29'b0, count}, 32'd0);
    checkOutput("reset_instr", {16'b0, instr}, 32'd0);
    checkOutput("reset_instr_pc", {16'b0, instr_pc}, 32'd0);
    checkOutput("reset_imem_addr", {16'b0, imem_addr}, 32'd0);

    // Streaming from reset release with a 1-cycle memory.
    repeat (2) @(posedge clk);
    #1;
    popLog.delete();
    reset = 1'b1;
    applyStimulus();
    firstK = -1;
    firstPc = '0;
    firstIn = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (instr_valid && firstK < 0) begin
        firstK  = k;
        firstPc = instr_pc;
        firstIn = instr;
      end
      tick();
    end
    checkOutput("first_valid_cycle", firstK, BYP ? 32'd1 : 32'd2);
    checkOutput("first_instr_pc", {16'b0, firstPc}, 32'h0000);
    checkOutput("first_instr", {16'b0, firstIn}, 32'h0000A5A5);
    checkSeq("stream", 16'h0000, 16'h0004, 16'h0008);

    // Decode stalled: the FIFO fills and requests stop, then one pop frees one credit.
    instrReadyPct = 0;
    repeat (8) tick();
    @(negedge clk);
    checkOutput("sat_count", {29'b0, count}, 32'd4);
    checkOutput("sat_req", {31'b0, imem_req}, 32'd0);
    instrReadyPct = 100;
    tick();
    instrReadyPct = 0;
    tick();
    @(negedge clk);
    checkOutput("after_pop_count", {29'b0, count}, 32'd3);
    checkOutput("after_pop_req", {31'b0, imem_req}, 32'd1);

    // 3-cycle memory, redirect while 8 and C are still outstanding.
    instrReadyPct = 100;
    memLat = 3;
    holdReset();
    repeat (3) tick();
    forceRedir = 1'b1;
    forcePc = 16'h0100;
    tick();
    popLog.delete();
    repeat (15) tick();
    checkSeq("redir", 16'h0100, 16'h0104, 16'h0108);
    stale = 0;
    foreach (popLog[i]) if (popLog[i] == 16'h0008 || popLog[i] == 16'h000C) stale++;
    checkOutput("no_stale_pc", stale, 32'd0);

    // PC wrap-around after a redirect near the top of the address space.
    memLat = 1;
    forceRedir = 1'b1;
    forcePc = 16'hFFFC;
    tick();
    popLog.delete();
    repeat (10) tick();
    checkSeq("wrap", 16'hFFFC, 16'h0000, 16'h0004);

    // Asynchronous reset with three entries buffered.
    instrReadyPct = 0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (count == 3'd3) seen = 1'b1;
      else tick();
    end
    checkOutput("reach_count3", {31'b0, seen}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("async_count", {29'b0, count}, 32'd0);
    checkOutput("async_valid", {31'b0, instr_valid}, 32'd0);
    checkOutput("async_req", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus();
    @(negedge clk);
    checkOutput("restart_addr", {16'b0, imem_addr}, 32'h0000);
    checkOutput("restart_req", {31'b0, imem_req}, 32'd1);

    // Randomized traffic: stalls, variable latency, redirects, spurious responses.
    imemReadyPct = 75;
    instrReadyPct = 65;
    redirPct = 4;
    spurPct = 5;
    for (int k = 0; k < 3000; k++) begin
      if (k % 200 == 0) memLat = $urandom_range(1, 4);
      tick();
    end
    redirPct = 0;
    spurPct = 0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
